avmm_led_sequencer: RTL
=======================

Name: avmm_led_sequencer

Overview:
- Avalon-MM initiator that drives the LED PIO responder from the FPGA fabric instead of the HPS.
- Writes an evolving pattern (count / walking-one / toggle) to a fixed PIO address at a programmable interval.
- Sits between local control logic (keys/switches) and the LED PIO port on the interconnect; reports status back to control.

Parameters:
- DATA_W, 4, LED pattern width; written into avm_writedata[DATA_W-1:0], upper bits zero.
- ADDR_W, 2, avm_address width (word address within the PIO span).
- TARGET_ADDR, 0, data register offset written each step.
- PERIOD_W, 24, width of interval counter and period input.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins sequence when idle.
- stop  in  1  one-cycle pulse; ends sequence at the next transfer boundary.
- mode  in  2  0 = binary count, 1 = walking one (rotate left), 2 = toggle (invert), 3 = hold (rewrite same value).
- period  in  PERIOD_W  clk cycles between write completions; sampled on accepted start.
- avm_address  out  ADDR_W  always TARGET_ADDR.
- avm_write  out  1  write request.
- avm_read  out  1  read request (verify feature only; else tied 0).
- avm_writedata  out  32  {zeros, pattern}.
- avm_readdata  in  32  read data.
- avm_waitrequest  in  1  responder stall.
- busy  out  1  high in any state except IDLE.
- pattern  out  DATA_W  last value issued.
- error  out  1  sticky verify mismatch.

Behaviour:
- Reset: state IDLE, avm_write = avm_read = 0, avm_writedata = 0, pattern = all-ones (matches PIO reset value), error = 0, busy = 0, timer = 0. Reset mid-transfer drops requests immediately; no completion is assumed.
- States: IDLE, WRITE, WAIT, READ and CHECK (READ/CHECK only with feature).
- IDLE:
  - An accepted start latches period_q = max(period, 1), loads pattern with the seed (count: 0, walk: 1, toggle: 0, hold: current pattern), and enters WRITE on the next cycle.
  - A stop pulse in IDLE is ignored.
- WRITE:
  - avm_write = 1; address and data stay stable while avm_waitrequest = 1.
  - The transfer completes in the cycle where write = 1 and waitrequest = 0. avm_write deasserts the following cycle.
  - On completion, go to WAIT (or READ with feature); timer loads period_q - 1.
- WAIT:
  - Timer decrements each cycle.
  - At timer = 0: if a stop is pending, go to IDLE. Otherwise advance pattern per mode and go to WRITE.
  - Advance rules: count wraps modulo 2^DATA_W (all-ones -> 0); walk rotates MSB into LSB; toggle inverts all bits.
  - Step latency: period_q cycles in WAIT, then 1 + number of waitrequest cycles in WRITE.
- stop:
  - The pulse is latched into stop_pend in any non-IDLE state.
  - A transfer in progress is never aborted.
  - Exit to IDLE happens at the next WAIT expiry or at WAIT entry, whichever comes first. Exit at WAIT entry means immediately after the current write (or verify) completes, with no further writes.
  - stop_pend clears on entry to IDLE.
- start while busy is ignored. Simultaneous start and stop in IDLE: start wins, and stop_pend is not set.
- mode is sampled at each advance, so a mode change takes effect on the next step without reseeding.
- busy = (state != IDLE).

Optional Feature:
- Macro: LED_SEQ_READBACK_VERIFY_EN.
- With the macro:
  - After each write completion, enter READ with avm_read = 1 until waitrequest = 0.
  - Capture readdata[DATA_W-1:0] in that cycle and go to CHECK.
  - CHECK, one cycle: on a mismatch with pattern, set error sticky (cleared only by reset or accepted start) and go to IDLE. Otherwise go to WAIT.
- Without the macro: no READ or CHECK states, avm_read is constant 0, error is constant 0.

Decomposition:
- Package avmm_led_seq_pkg holds:
  - state enum;
  - mode encoding constants MODE_COUNT / MODE_WALK / MODE_TOGGLE / MODE_HOLD;
  - seed constants.
- One sub-module, led_pattern_step: combinational next-pattern function of (mode, pattern). Kept separate so it can be unit-tested alone.
- Timer and FSM stay in the top module.

Test Plan:
- Reset, then start with mode = 0, period = 3, waitrequest = 0 -> writes 0, 1, 2, … with write-completion edges exactly 4 cycles apart; after 0xF the next value is 0x0.
- Mode = 1, period = 1, waitrequest high for 2 cycles on each write -> writedata 0x1, 0x2, 0x4, 0x8, 0x1; address and data stable during the stall; each write lasts 3 cycles.
- Stop pulsed mid-stall of a write -> that write completes, no further write is issued, busy falls the cycle after completion, pattern holds its value.
- period = 0 with mode = 2 -> treated as 1; pattern alternates 0x0 / 0xF; a start pulsed while busy has no effect.
- Reset asserted while avm_write = 1 -> avm_write = 0 and pattern = 0xF asynchronously; the next start reseeds normally.
- Verify feature: responder returns 0x3 for a write of 0x2 -> error = 1 after CHECK, FSM in IDLE, no further writes; a new start clears error.

Source files
------------

// File: rtl/avmm_led_seq_pkg.sv
// Shared types and constants for the Avalon-MM LED sequencer.
package avmm_led_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWait,
    StRead,
    StCheck
  } state_e;

  localparam logic [1:0] MODE_COUNT  = 2'd0;
  localparam logic [1:0] MODE_WALK   = 2'd1;
  localparam logic [1:0] MODE_TOGGLE = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  // Hold mode has no seed: it keeps whatever pattern is current.
  localparam int unsigned SEED_COUNT  = 0;
  localparam int unsigned SEED_WALK   = 1;
  localparam int unsigned SEED_TOGGLE = 0;

endpackage

// File: rtl/avmm_led_sequencer_if.sv
// Avalon-MM bus between the LED sequencer (master) and the LED PIO responder (slave).
interface avmm_led_sequencer_if #(
  parameter int unsigned ADDR_W = 2
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic              avm_read;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_write, avm_read, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_write, avm_read, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/led_pattern_step.sv
// Combinational next-pattern function for the LED sequencer.
module led_pattern_step
  import avmm_led_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 4
) (
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_pattern,
  output logic [DATA_W-1:0] o_next
);

  always_comb begin
    o_next = i_pattern;
    unique case (i_mode)
      MODE_COUNT:  o_next = i_pattern + DATA_W'(1);
      MODE_WALK:   o_next = {i_pattern[DATA_W-2:0], i_pattern[DATA_W-1]};
      MODE_TOGGLE: o_next = ~i_pattern;
      default:     o_next = i_pattern;
    endcase
  end

endmodule

// File: rtl/avmm_led_sequencer.sv
// Avalon-MM initiator writing an evolving LED pattern to a PIO at a programmable interval.
// Define LED_SEQ_READBACK_VERIFY_EN to read back and check every write.
module avmm_led_sequencer
  import avmm_led_seq_pkg::*;
#(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned TARGET_ADDR = 0,
  parameter int unsigned PERIOD_W    = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [1:0]          i_mode,
  input  logic [PERIOD_W-1:0] i_period,
  avmm_led_sequencer_if.master avm,
  output logic                o_busy,
  output logic [DATA_W-1:0]   o_pattern,
  output logic                o_error
);

  state_e              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_pattern, w_pattern_nxt, w_step, w_seed;
  logic [PERIOD_W-1:0] r_period, w_period_nxt, r_timer, w_timer_nxt;
  logic                r_stop_pend, w_stop_pend_nxt, r_error, w_error_nxt, w_stop_req;
`ifdef LED_SEQ_READBACK_VERIFY_EN
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
`else
  logic                w_unused_rdata;
  assign w_unused_rdata = ^avm.avm_readdata;
`endif

  led_pattern_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .i_mode    (i_mode),
    .i_pattern (r_pattern),
    .o_next    (w_step)
  );

  always_comb begin
    w_seed = r_pattern;
    unique case (i_mode)
      MODE_COUNT:  w_seed = DATA_W'(SEED_COUNT);
      MODE_WALK:   w_seed = DATA_W'(SEED_WALK);
      MODE_TOGGLE: w_seed = DATA_W'(SEED_TOGGLE);
      default:     w_seed = r_pattern;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_pattern   <= '1;
      r_period    <= '0;
      r_timer     <= '0;
      r_stop_pend <= 1'b0;
      r_error     <= 1'b0;
`ifdef LED_SEQ_READBACK_VERIFY_EN
      r_rdata     <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_pattern   <= w_pattern_nxt;
      r_period    <= w_period_nxt;
      r_timer     <= w_timer_nxt;
      r_stop_pend <= w_stop_pend_nxt;
      r_error     <= w_error_nxt;
`ifdef LED_SEQ_READBACK_VERIFY_EN
      r_rdata     <= w_rdata_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pattern_nxt   = r_pattern;
    w_period_nxt    = r_period;
    w_timer_nxt     = r_timer;
    w_error_nxt     = r_error;
    w_stop_pend_nxt = r_stop_pend;
    // A stop arriving in the very cycle of a boundary must still take effect there.
    w_stop_req      = r_stop_pend | i_stop;
`ifdef LED_SEQ_READBACK_VERIFY_EN
    w_rdata_nxt     = r_rdata;
`endif
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_nxt   = StWrite;
          w_period_nxt  = (i_period == '0) ? PERIOD_W'(1) : i_period;
          w_pattern_nxt = w_seed;
          w_error_nxt   = 1'b0;
        end
      end
      StWrite: begin
        if (!avm.avm_waitrequest) begin
          w_timer_nxt = r_period - PERIOD_W'(1);
`ifdef LED_SEQ_READBACK_VERIFY_EN
          w_state_nxt = StRead;
`else
          w_state_nxt = w_stop_req ? StIdle : StWait;
`endif
        end
      end
      StWait: begin
        if (r_timer == '0) begin
          if (w_stop_req) begin
            w_state_nxt = StIdle;
          end else begin
            w_pattern_nxt = w_step;
            w_state_nxt   = StWrite;
          end
        end else begin
          w_timer_nxt = r_timer - PERIOD_W'(1);
        end
      end
`ifdef LED_SEQ_READBACK_VERIFY_EN
      StRead: begin
        if (!avm.avm_waitrequest) begin
          w_rdata_nxt = avm.avm_readdata[DATA_W-1:0];
          w_state_nxt = StCheck;
        end
      end
      StCheck: begin
        if (r_rdata != r_pattern) begin
          w_error_nxt = 1'b1;
          w_state_nxt = StIdle;
        end else begin
          w_state_nxt = w_stop_req ? StIdle : StWait;
        end
      end
`endif
      default: w_state_nxt = StIdle;
    endcase
    if (r_state != StIdle && i_stop) w_stop_pend_nxt = 1'b1;
    if (w_state_nxt == StIdle) w_stop_pend_nxt = 1'b0;
  end

  assign avm.avm_address   = ADDR_W'(TARGET_ADDR);
  assign avm.avm_write     = (r_state == StWrite);
  assign avm.avm_writedata = (r_state == StWrite) ? {{(32 - DATA_W){1'b0}}, r_pattern} : '0;
`ifdef LED_SEQ_READBACK_VERIFY_EN
  assign avm.avm_read      = (r_state == StRead);
`else
  assign avm.avm_read      = 1'b0;
`endif
  assign o_busy    = (r_state != StIdle);
  assign o_pattern = r_pattern;
  assign o_error   = r_error;

endmodule
